booth_mul_iter: RTL and testbench



---
 rtl/booth_iter_pkg.sv | 36 +++
 rtl/booth_pp_gen.sv | 35 +++
 rtl/booth_mul_iter.sv | 117 +++++++++++
 tb/tb_booth_mul_iter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/booth_iter_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package booth_iter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Booth digit triples {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] DigZeroP = 3'b000;
  localparam logic [2:0] DigP1Lo  = 3'b001;
  localparam logic [2:0] DigP1Hi  = 3'b010;
  localparam logic [2:0] DigP2    = 3'b011;
  localparam logic [2:0] DigM2    = 3'b100;
  localparam logic [2:0] DigM1Lo  = 3'b101;
  localparam logic [2:0] DigM1Hi  = 3'b110;
  localparam logic [2:0] DigZeroN = 3'b111;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

  function automatic int unsigned ndig(input int unsigned b_len);
    return b_len / 2 + 1;
  endfunction

  function automatic int unsigned ncyc(input int unsigned b_len, input int unsigned dpc);
    return ceil_div(ndig(b_len), dpc);
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth digit: encoder plus partial-product generator.
module booth_pp_gen
  import booth_iter_pkg::*;
#(
  parameter int unsigned A_LEN = 256
) (
  input  logic [2:0]       digit_i,
  input  logic [A_LEN:0]   a_i,
  output logic [A_LEN+1:0] pp_o,
  output logic             neg_o
);

  logic [A_LEN+1:0] mag;

  // Negative digits emit ~mag; the +1 is returned as neg_o for the accumulator.
  always_comb begin
    mag   = '0;
    neg_o = 1'b0;
    case (digit_i)
      DigZeroP, DigZeroN: mag = '0;
      DigP1Lo, DigP1Hi:   mag = {a_i[A_LEN], a_i};
      DigP2:              mag = {a_i, 1'b0};
      DigM2: begin
        mag   = {a_i, 1'b0};
        neg_o = 1'b1;
      end
      DigM1Lo, DigM1Hi: begin
        mag   = {a_i[A_LEN], a_i};
        neg_o = 1'b1;
      end
    endcase
    pp_o = neg_o ? ~mag : mag;
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier retiring DIGITS_PER_CYC digits per clock,
// signed/unsigned per operation, valid/ready on both sides.
module booth_mul_iter
  import booth_iter_pkg::*;
#(
  parameter int unsigned A_LEN          = 256,
  parameter int unsigned B_LEN          = 64,
  parameter int unsigned DIGITS_PER_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     in_signed_i,
  input  logic [A_LEN-1:0]         a_i,
  input  logic [B_LEN-1:0]         b_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [A_LEN+B_LEN-1:0]   p_o,
  output logic                     busy_o
);

  localparam int unsigned P_LEN = A_LEN + B_LEN;
  localparam int unsigned NDIG  = ndig(B_LEN);
  localparam int unsigned NCYC  = ncyc(B_LEN, DIGITS_PER_CYC);
  localparam int unsigned CW    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int unsigned BW    = max_u(B_LEN + 3, 2 * DIGITS_PER_CYC + 1);
  localparam logic [CW-1:0] CntLast = CW'(NCYC - 1);

  state_e                                state_q;
  logic [CW-1:0]                         cnt_q;
  logic [A_LEN:0]                        a_q;
  logic [BW-1:0]                         b_q;
  logic [P_LEN-1:0]                      acc_q, acc_d;
  logic [31:0]                           base;
  logic [P_LEN-1:0]                      term;
  logic [DIGITS_PER_CYC-1:0]             slot_en;
  logic [DIGITS_PER_CYC-1:0][2:0]        dig_w;
  logic [DIGITS_PER_CYC-1:0][A_LEN+1:0]  pp_w;
  logic [DIGITS_PER_CYC-1:0]             neg_w;

  assign p_o  = acc_q;
  assign base = 32'(cnt_q) * DIGITS_PER_CYC;

  // b_q holds the extended multiplier with a 0 below bit 0, shifted down each cycle
  // so slot j always reads its triple from b_q[2j+2:2j].
  for (genvar j = 0; j < DIGITS_PER_CYC; j++) begin : g_slot
    assign slot_en[j] = (base + 32'(j)) < NDIG;
    assign dig_w[j]   = slot_en[j] ? b_q[2*j+2 -: 3] : DigZeroP;

    booth_pp_gen #(
      .A_LEN(A_LEN)
    ) u_pp_gen (
      .digit_i(dig_w[j]),
      .a_i    (a_q),
      .pp_o   (pp_w[j]),
      .neg_o  (neg_w[j])
    );
  end

  always_comb begin
    acc_d = acc_q;
    term  = '0;
    for (int unsigned j = 0; j < DIGITS_PER_CYC; j++) begin
      term             = {P_LEN{pp_w[j][A_LEN+1]}};
      term[A_LEN+1:0]  = pp_w[j];
      term             = term + P_LEN'(neg_w[j]);
      acc_d            = acc_d + (term << (2 * (base + j)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q        <= {in_signed_i & a_i[A_LEN-1], a_i};
            b_q        <= {{(BW - 1 - B_LEN){in_signed_i & b_i[B_LEN-1]}}, b_i, 1'b0};
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= StBusy;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        StBusy: begin
          acc_q <= acc_d;
          b_q   <= $unsigned($signed(b_q) >>> (2 * DIGITS_PER_CYC));
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CntLast) begin
            state_q     <= StDone;
            out_valid_o <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench: directed 256x64 cases plus randomized 8x8 sweep over three
// DIGITS_PER_CYC settings, all against a plain-arithmetic reference.
module tb_booth_mul_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_signed, out_ready;
  logic [255:0] a;
  logic [63:0]  b;
  logic         in_ready, out_valid, busy;
  logic [319:0] p;

  logic         s_in_valid, s_signed, s_out_ready;
  logic [7:0]   s_a, s_b;
  logic         s_ir   [3];
  logic         s_ov   [3];
  logic         s_busy [3];
  logic [15:0]  s_p    [3];

  int checks = 0;
  int errors = 0;
  int exp_lat [3] = '{5, 3, 1};

  always #5 clk = ~clk;

  booth_mul_iter #(.A_LEN(256), .B_LEN(64), .DIGITS_PER_CYC(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_signed_i(in_signed), .a_i(a), .b_i(b), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .p_o(p), .busy_o(busy)
  );

  booth_mul_iter #(.A_LEN(8), .B_LEN(8), .DIGITS_PER_CYC(1)) u_dut_d1 (
    .clk(clk), .rst(rst), .in_valid_i(s_in_valid), .in_ready_o(s_ir[0]),
    .in_signed_i(s_signed), .a_i(s_a), .b_i(s_b), .out_valid_o(s_ov[0]),
    .out_ready_i(s_out_ready), .p_o(s_p[0]), .busy_o(s_busy[0])
  );

  booth_mul_iter #(.A_LEN(8), .B_LEN(8), .DIGITS_PER_CYC(2)) u_dut_d2 (
    .clk(clk), .rst(rst), .in_valid_i(s_in_valid), .in_ready_o(s_ir[1]),
    .in_signed_i(s_signed), .a_i(s_a), .b_i(s_b), .out_valid_o(s_ov[1]),
    .out_ready_i(s_out_ready), .p_o(s_p[1]), .busy_o(s_busy[1])
  );

  booth_mul_iter #(.A_LEN(8), .B_LEN(8), .DIGITS_PER_CYC(5)) u_dut_d5 (
    .clk(clk), .rst(rst), .in_valid_i(s_in_valid), .in_ready_o(s_ir[2]),
    .in_signed_i(s_signed), .a_i(s_a), .b_i(s_b), .out_valid_o(s_ov[2]),
    .out_ready_i(s_out_ready), .p_o(s_p[2]), .busy_o(s_busy[2])
  );

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Extend both operands to the full product width and multiply modulo 2^320.
  function automatic logic [319:0] ref_big(input logic [255:0] x, input logic [63:0] y,
                                           input logic s);
    logic [319:0] ex, ey;
    ex = {{64{s & x[255]}}, x};
    ey = {{256{s & y[63]}}, y};
    return ex * ey;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input logic s);
    logic [15:0] ex, ey;
    ex = {{8{s & x[7]}}, x};
    ey = {{8{s & y[7]}}, y};
    return ex * ey;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_big(input string tag, input logic [255:0] ta, input logic [63:0] tb,
                         input logic ts, input logic [319:0] exp, input int hold);
    int k;
    @(negedge clk);
    check({tag, "/idle_rdy"}, 320'(in_ready), 320'd1);
    a = ta; b = tb; in_signed = ts; in_valid = 1'b1;
    @(negedge clk);
    // Keep in_valid high with junk operands: must be ignored while busy.
    a = ~ta; b = ~tb; in_signed = ~ts;
    check({tag, "/busy"}, 320'({busy, in_ready}), 320'(2'b10));
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "/lat"}, 320'(k), 320'd9);
    check({tag, "/p"}, p, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/bp_p"}, p, exp);
      check({tag, "/bp_hs"}, 320'({out_valid, in_ready}), 320'(2'b10));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/ret"}, 320'({out_valid, in_ready, busy}), 320'(3'b010));
  endtask

  task automatic run_small(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
    int lat [3];
    int k;
    logic [15:0] exp;
    exp = ref8(ta, tb, ts);
    lat = '{-1, -1, -1};
    @(negedge clk);
    s_a = ta; s_b = tb; s_signed = ts; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0; s_a = ~ta; s_b = ~tb; s_signed = ~ts;
    k = 0;
    while (k < 12 && !(s_ov[0] && s_ov[1] && s_ov[2])) begin
      for (int d = 0; d < 3; d++) if (s_ov[d] && lat[d] < 0) lat[d] = k;
      @(negedge clk);
      k++;
    end
    for (int d = 0; d < 3; d++) if (s_ov[d] && lat[d] < 0) lat[d] = k;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("s%0d_lat a=%0h b=%0h s=%0b", d, ta, tb, ts), 320'(lat[d]),
            320'(exp_lat[d]));
      check($sformatf("s%0d_p a=%0h b=%0h s=%0b", d, ta, tb, ts), 320'(s_p[d]), 320'(exp));
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("s_ret", 320'({s_ir[0], s_ir[1], s_ir[2], s_ov[0], s_ov[1], s_ov[2]}),
          320'(6'b111000));
  endtask

  initial begin
    logic [7:0]   corners [8];
    logic [255:0] ra;
    logic [63:0]  rb;
    logic         rs;
    logic         seen;
    corners = '{8'h00, 8'h01, 8'h02, 8'h7f, 8'h80, 8'h81, 8'hfe, 8'hff};

    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    s_in_valid = 1'b0; s_signed = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 320'(in_ready), 320'd1);
    check("rst_out_valid", 320'(out_valid), 320'd0);
    check("rst_busy", 320'(busy), 320'd0);
    check("rst_p", p, 320'd0);

    run_big("u_ones", '1, '1, 1'b0, 320'd1 - (320'd1 << 256) - (320'd1 << 64), 5);
    run_big("s_ones", '1, '1, 1'b1, 320'd1, 0);
    run_big("s_ext", 256'd1 << 255, 64'd1 << 63, 1'b1, 320'd1 << 318, 0);
    run_big("s_5m3", 256'd5, 64'hffff_ffff_ffff_fffd, 1'b1, 320'd0 - 320'd15, 0);
    run_big("a_zero", '0, rand64(), 1'b1, 320'd0, 0);
    run_big("b_zero", rand256(), '0, 1'b0, 320'd0, 0);
    for (int i = 0; i < 8; i++) begin
      ra = rand256(); rb = rand64(); rs = 1'($urandom);
      run_big("rand", ra, rb, rs, ref_big(ra, rb, rs), i % 2);
    end

    // Abandon an operation four cycles into BUSY.
    @(negedge clk);
    a = rand256(); b = rand64(); in_signed = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst", 320'({in_ready, out_valid, busy}), 320'(3'b100));
    check("mid_rst_p", p, 320'd0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("no_stale_valid", 320'(seen), 320'd0);
    run_big("after_rst", 256'd3, 64'd7, 1'b0, 320'd21, 0);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) run_small(corners[i], corners[j], 1'(s));
    for (int n = 0; n < 300; n++) run_small(8'($urandom), 8'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
